// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
//
// Load/store bridge between the core's data-memory port and a split
// read/write handshaked data bus. It takes one request at a time, checks
// alignment and opcode legality, and runs the transfer on the bus. Load data
// comes back to the core already byte-extracted and sign/zero-extended.
// The core is stalled through req_ready (high only when idle) until the
// one-cycle resp_valid pulse.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   req_*               core request (valid/ready, wen, funct3 op, addr, wdata)
//   resp_*              completion pulse, extended load data, error flag
//   rd_addr_*           read address channel (word aligned)
//   rd_data_*, rd_resp_err
//                       read data channel with bus error
//   wr_*                write channel (address, lane-positioned data, strobes)
//   wr_resp_*           write response channel with bus error
//
// Parameters
//   TIMEOUT_CYCLES      cycles allowed in any one bus-wait state before the
//                       transfer is aborted with an error; 0 disables it
//   ADDR_W              address width
// -----------------------------------------------------------------------------
module lsu_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,

   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,

   output logic              rd_addr_valid,
   input  logic              rd_addr_ready,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_data_valid,
   output logic              rd_data_ready,
   input  logic [31:0]       rd_data,
   input  logic              rd_resp_err,

   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [3:0]        wr_strb,
   input  logic              wr_resp_valid,
   output logic              wr_resp_ready,
   input  logic              wr_resp_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_ADDR = 3'd1;
   localparam logic [2:0] S_RD_DATA = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_WR_RESP = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
   // The abort fires on the last allowed cycle, so a state is occupied for
   // exactly TIMEOUT_CYCLES cycles before the move to RESP.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [2:0]        state, state_nxt;
   logic [CNT_W-1:0]  tcount;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              req_bad;
   logic              bus_wait;
   logic              tmo_hit;
   logic              tmo_take;
   logic [31:0]       rd_shift;
   logic [31:0]       load_ext;

   // Misaligned halfword/word accesses and opcodes that do not exist for the
   // request direction are rejected without touching the bus.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first so no path leaves it unassigned and no latch is inferred.
      req_bad = 1'b1;
      case (req_op)
         3'b000:  req_bad = 1'b0;
         3'b001:  req_bad = req_addr[0];
         3'b010:  req_bad = |req_addr[1:0];
         3'b100:  req_bad = req_wen;
         3'b101:  req_bad = req_wen | req_addr[0];
         default: req_bad = 1'b1;
      endcase
   end

   assign bus_wait = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                     (state == S_WR_REQ)  || (state == S_WR_RESP);
   assign tmo_hit  = TMO_EN && bus_wait && (tcount == TMO_LAST);

   // Next state. A handshake completing in the same cycle as the timeout wins.
   always_comb begin
      state_nxt = state;
      tmo_take  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_bad)      state_nxt = S_RESP;
               else if (req_wen) state_nxt = S_WR_REQ;
               else              state_nxt = S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            if (rd_addr_ready)  state_nxt = S_RD_DATA;
            else if (tmo_hit) begin state_nxt = S_RESP; tmo_take = 1'b1; end
         end
         S_RD_DATA: begin
            if (rd_data_valid)  state_nxt = S_RESP;
            else if (tmo_hit) begin state_nxt = S_RESP; tmo_take = 1'b1; end
         end
         S_WR_REQ: begin
            if (wr_ready)       state_nxt = S_WR_RESP;
            else if (tmo_hit) begin state_nxt = S_RESP; tmo_take = 1'b1; end
         end
         S_WR_RESP: begin
            if (wr_resp_valid)  state_nxt = S_RESP;
            else if (tmo_hit) begin state_nxt = S_RESP; tmo_take = 1'b1; end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Load extraction: bring the addressed byte/halfword down to bit 0, then
   // sign- or zero-extend according to funct3.
   assign rd_shift = rd_data >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_ext = rd_data;
      case (op_q)
         3'b000:  load_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
         3'b100:  load_ext = {24'd0,              rd_shift[7:0]};
         3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b101:  load_ext = {16'd0,              rd_shift[15:0]};
         default: load_ext = rd_data;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         // NOTE: the captured request fields are reset as well, so the bus
         // outputs derived from them are deterministic straight out of reset.
         state   <= S_IDLE;
         tcount  <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state_nxt != state) tcount <= '0;
         else if (bus_wait)      tcount <= tcount + CNT_W'(1);

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  err_q   <= req_bad;
               end
            end
            S_RD_DATA: begin
               if (rd_data_valid) begin
                  err_q   <= rd_resp_err;
                  rdata_q <= rd_resp_err ? 32'd0 : load_ext;
               end
            end
            S_WR_RESP: begin
               if (wr_resp_valid) err_q <= wr_resp_err;
            end
            default: ;
         endcase

         // Timeout leaves rdata_q at the zero loaded on acceptance.
         if (tmo_take) err_q <= 1'b1;
      end
   end

   // Outputs are decoded from the state; address/data buses are forced to
   // zero outside their valid window.
   assign req_ready     = (state == S_IDLE);
   assign resp_valid    = (state == S_RESP);
   assign resp_rdata    = resp_valid ? rdata_q : 32'd0;
   assign resp_err      = resp_valid & err_q;

   assign rd_addr_valid = (state == S_RD_ADDR);
   assign rd_addr       = rd_addr_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign rd_data_ready = (state == S_RD_DATA);

   assign wr_valid      = (state == S_WR_REQ);
   assign wr_addr       = wr_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign wr_data       = wr_valid ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
   assign wr_resp_ready = (state == S_WR_RESP);

   always_comb begin
      wr_strb = 4'b0000;
      if (wr_valid) begin
         case (op_q[1:0])
            2'b00:   wr_strb = 4'b0001 << addr_q[1:0];
            2'b01:   wr_strb = 4'b0011 << addr_q[1:0];
            default: wr_strb = 4'b1111;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_bridge
//
// Self-checking bench for lsu_bus_bridge (TIMEOUT_CYCLES = 8). The bench acts
// as the core and as a bus slave with programmable wait states; expected
// results come from a byte-level reference model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_lsu_bus_bridge;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        rd_addr_valid, rd_addr_ready, rd_data_valid, rd_data_ready, rd_resp_err;
   logic [31:0] rd_addr, rd_data;
   logic        wr_valid, wr_ready, wr_resp_valid, wr_resp_ready, wr_resp_err;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_bus_bridge #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
      .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
      .rd_resp_err(rd_resp_err),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
      .wr_resp_err(wr_resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [2:0] op);
      case (op[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit op_legal(input bit wen, input logic [2:0] op);
      if (op_size(op) == 0) return 0;
      if (wen) return (op[2] == 1'b0);
      return !(op[2] && op_size(op) == 4);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
      int     size = op_size(op);
      int     off  = int'(addr % 4);
      longint v    = 0;
      if (size == 4) return word;
      for (int i = 0; i < size; i++)
         v = v + (longint'(word[8*(off+i) +: 8]) << (8*i));
      if (!op[2] && v >= (longint'(1) << (8*size-1)))
         v = v - (longint'(1) << (8*size));
      return 32'(v);
   endfunction

   task automatic clear_bus();
      rd_addr_ready = 0; rd_data_valid = 0; rd_resp_err = 0; rd_data = 0;
      wr_ready = 0; wr_resp_valid = 0; wr_resp_err = 0;
   endtask

   // Runs one request end to end. Starts and ends just after a negedge.
   // aw: wait cycles before address-phase ready; dw: wait before data/response.
   task automatic run_txn(input string tag, input bit wen, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int aw, input int dw,
                          input bit berr);
      int          size, lat_exp, bus_exp;
      int          lat_obs = 0, bus_obs = 0, a_cnt = 0, d_cnt = 0;
      bit          legal, tmo = 0, stable = 1, rr_bad = 0;
      logic        exp_err, err_obs = 0;
      logic [31:0] exp_rdata, rdata_obs = 0, cap_addr = 0, cap_data = 0;
      logic [31:0] mask = 0, exp_wdata = 0;
      logic [3:0]  cap_strb = 0, exp_strb = 0;

      size  = op_size(op);
      legal = op_legal(wen, op);
      if (legal) legal = ((addr % size) == 0);
      if (!legal)           begin lat_exp = 1;                 bus_exp = 0;      end
      else if (aw >= T)     begin lat_exp = 1 + T;             bus_exp = T;      tmo = 1; end
      else if (dw >= T)     begin lat_exp = 1 + (aw + 1) + T;  bus_exp = aw + 1; tmo = 1; end
      else                  begin lat_exp = 1 + (aw + 1) + (dw + 1); bus_exp = aw + 1; end
      exp_err   = !legal || tmo || berr;
      exp_rdata = (exp_err || wen) ? 32'd0 : model_load(op, addr, rword);
      if (legal && wen) begin
         for (int i = 0; i < size; i++) begin
            exp_strb[(addr % 4) + i] = 1'b1;
            mask[8*((addr % 4) + i) +: 8] = 8'hFF;
            exp_wdata[8*((addr % 4) + i) +: 8] = wdata[8*i +: 8];
         end
      end

      req_valid = 1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      for (int c = 1; c <= 60; c++) begin
         clear_bus();
         rd_data = rword;
         if (req_ready) rr_bad = 1;
         if (resp_valid) begin lat_obs = c; rdata_obs = resp_rdata; err_obs = resp_err; end
         if (rd_addr_valid) begin
            bus_obs++; a_cnt++;
            if (a_cnt == 1) cap_addr = rd_addr; else if (rd_addr !== cap_addr) stable = 0;
            rd_addr_ready = (a_cnt > aw);
            if ($urandom_range(0, 1) == 1) begin rd_data_valid = 1; rd_data = ~rword; rd_resp_err = 1; end
         end
         if (rd_data_ready) begin
            d_cnt++;
            rd_data_valid = (d_cnt > dw);
            rd_resp_err   = berr;
         end
         if (wr_valid) begin
            bus_obs++; a_cnt++;
            if (a_cnt == 1) begin cap_addr = wr_addr; cap_data = wr_data; cap_strb = wr_strb; end
            else if (wr_addr !== cap_addr || wr_data !== cap_data || wr_strb !== cap_strb) stable = 0;
            wr_ready = (a_cnt > aw);
            if ($urandom_range(0, 1) == 1) begin wr_resp_valid = 1; wr_resp_err = 1; end
         end
         if (wr_resp_ready) begin
            d_cnt++;
            wr_resp_valid = (d_cnt > dw);
            wr_resp_err   = berr;
         end
         if (resp_valid) begin
            req_valid = 0;
            break;
         end
         // Junk on the request port while busy must be ignored.
         req_valid = 1'($urandom_range(0, 1)); req_wen = 1'($urandom_range(0, 1));
         req_op = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
         @(negedge clk);
      end
      clear_bus();
      req_valid = 0;

      check({tag, " latency"},   32'(lat_obs), 32'(lat_exp));
      check({tag, " rdata"},     rdata_obs, exp_rdata);
      check({tag, " err"},       32'(err_obs), 32'(exp_err));
      check({tag, " bus_cycles"},32'(bus_obs), 32'(bus_exp));
      check({tag, " busy_ready"},32'(rr_bad), 32'd0);
      if (legal) begin
         check({tag, " bus_stable"}, 32'(stable), 32'd1);
         check({tag, " bus_addr"},   cap_addr, {addr[31:2], 2'b00});
         if (wen) begin
            check({tag, " wr_strb"}, 32'(cap_strb), 32'(exp_strb));
            check({tag, " wr_data"}, cap_data & mask, exp_wdata);
         end
      end
      @(negedge clk);
      check({tag, " resp_single"}, 32'(resp_valid), 32'd0);
      check({tag, " ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst = 0;
      req_valid = 0; req_wen = 0; req_op = 0; req_addr = 0; req_wdata = 0;
      clear_bus();
      repeat (2) @(negedge clk);

      // Reset state: everything low except req_ready.
      check("reset outputs",
            {resp_valid, resp_err, rd_addr_valid, rd_data_ready, wr_valid, wr_resp_ready, wr_strb},
            32'd0);
      check("reset buses", resp_rdata | rd_addr | wr_addr | wr_data, 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd1);
      rst = 1;
      @(negedge clk);

      // Directed cases.
      run_txn("LB",  0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
      check("LB value", model_load(3'b000, 32'h8000_0003, 32'h80FF_1234), 32'hFFFF_FF80);
      run_txn("LBU", 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
      run_txn("SH",  1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 0);
      run_txn("LW misaligned", 0, 3'b010, 32'h8000_0006, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
      run_txn("LH wait", 0, 3'b001, 32'h8000_0010, 32'h0, 32'h1234_0000, 5, 3, 0);
      run_txn("SW timeout", 1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 100, 0, 0);
      run_txn("LW rdata timeout", 0, 3'b010, 32'h0000_0040, 32'h0, 32'h1111_2222, 1, 100, 0);
      run_txn("LHU bus err", 0, 3'b101, 32'h0000_0042, 32'h0, 32'hFFFF_0000, 0, 1, 1);
      run_txn("SB bus err", 1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 32'h0, 2, 0, 1);
      run_txn("SBU illegal", 1, 3'b100, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);
      run_txn("op 011 illegal", 0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);

      // Reset while in RD_DATA, then a late read-data beat.
      req_valid = 1; req_wen = 0; req_op = 3'b010; req_addr = 32'h0000_0200; req_wdata = 0;
      @(negedge clk);
      req_valid = 0; rd_addr_ready = 1;
      @(negedge clk);
      rd_addr_ready = 0;
      check("rst test in RD_DATA", 32'(rd_data_ready), 32'd1);
      rst = 0;
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         rd_data_valid = 1; rd_data = 32'h5555_AAAA;
         @(negedge clk);
         check("late beat resp_valid", 32'(resp_valid), 32'd0);
         check("late beat rd_data_ready", 32'(rd_data_ready), 32'd0);
         check("late beat req_ready", 32'(req_ready), 32'd1);
      end
      clear_bus();
      run_txn("LW after rst", 0, 3'b010, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 0, 0, 0);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         bit          wen   = 1'($urandom_range(0, 1));
         logic [2:0]  op    = 3'($urandom_range(0, 7));
         logic [31:0] addr  = $urandom;
         int          aw    = ($urandom_range(0, 9) == 0) ? T + 2 : int'($urandom_range(0, 3));
         int          dw    = ($urandom_range(0, 9) == 0) ? T + 1 : int'($urandom_range(0, 3));
         bit          berr  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         run_txn("rand", wen, op, addr, $urandom, $urandom, aw, dw, berr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
